muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with integrated HI/LO registers, sitting in the EX stage of the 5-stage MIPS datapath. It replaces the fixed 32-bit divider and the separate HI/LO pipeline flops. It executes MULT/MULTU/DIV/DIVU as a multi-cycle operation under a start/busy/done handshake, and supports cancellation on pipeline flush. It also supports direct HI/LO writes for MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// One bit per cycle over WIDTH cycles, then a sign fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT              state;
    stateT              nextState;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   aReg;
    logic               isDiv;
    logic               negQ;
    logic               negRem;
    logic               divZero;

    logic               accept;
    logic               inFlight;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     sumHi;
    logic [2*WIDTH-1:0] mulStep;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   remShift;
    logic [WIDTH-1:0]   newRem;
    logic [2*WIDTH-1:0] divStep;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    assign inFlight = (state == CALC) || (state == FIX);
    assign accept   = start & ~cancel & ((state == IDLE) || (state == DONE));
    assign busy     = ~rst & (inFlight | accept);
    assign done     = (state == DONE);
    assign div0     = done & divZero;

    // Signed ops (op[0] set) work on magnitudes; signs are reapplied in FIX.
    assign magA = (op[0] & a[WIDTH-1]) ? -a : a;
    assign magB = (op[0] & b[WIDTH-1]) ? -b : b;

    // Accumulator upper half is the partial product / remainder,
    // lower half the multiplier bits / dividend-then-quotient bits.
    assign rem     = acc[2*WIDTH-1:WIDTH];
    assign quo     = acc[WIDTH-1:0];
    assign sumHi   = {1'b0, rem} + {1'b0, (acc[0] ? mcand : '0)};
    assign mulStep = {sumHi, quo[WIDTH-1:1]};

    // The true difference always fits WIDTH bits when it is taken.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign ge       = shifted >= {1'b0, mcand};
    assign remShift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign newRem   = ge ? (remShift - mcand) : remShift;
    assign divStep  = {newRem, quo[WIDTH-2:0], ge};

    assign prod = negQ ? -acc : acc;

    // Final HI/LO values presented during FIX.
    always_comb begin
        resHi = prod[2*WIDTH-1:WIDTH];
        resLo = prod[WIDTH-1:0];
        if (isDiv) begin
            resLo = negQ ? -quo : quo;
            resHi = negRem ? -rem : rem;
            if (divZero) begin
                resLo = '1;
                resHi = aReg;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state: cancel always wins, DONE may chain a new operation.
    always_comb begin
        nextState = state;
        if (cancel) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) nextState = CALC;
                CALC:    if (cnt == LAST) nextState = FIX;
                FIX:     nextState = DONE;
                DONE:    nextState = start ? CALC : IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Operand capture and one iteration per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            aReg    <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, magA};
            mcand   <= magB;
            aReg    <= a;
            isDiv   <= op[1];
            negQ    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem  <= op[0] & op[1] & a[WIDTH-1];
            divZero <= op[1] & (b == '0);
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= isDiv ? divStep : mulStep;
        end
    end

    // HI/LO: result at the edge leaving FIX, else direct writes when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!cancel) begin
                hi <= resHi;
                lo <= resLo;
            end
        end else if (!inFlight) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at WIDTH 32 and 8.
// Expected values are hand-computed constants.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, cancel, hiWe, loWe;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    logic       rst8, start8;
    logic [1:0] op8;
    logic [7:0] a8, b8;
    logic       busy8, done8, div08;
    logic [7:0] hi8, lo8;

    int nChecks = 0;
    int nFail   = 0;
    int cycNo   = 0;
    int tStart  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_we(hiWe), .lo_we(loWe), .wdata(wdata),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .cancel(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycNo++;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input string tag);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        check({tag, " busy@T"}, busy, 1);
        tStart = cycNo;
        cyc();
        start = 1'b0;
        a = 32'h5A5A_5A5A;
        b = 32'h0000_0003;
        op = 2'b01;
    endtask

    task automatic waitDone(input string tag, input logic [31:0] eHi,
                            input logic [31:0] eLo, input logic eDiv0);
        logic held;
        held = 1'b1;
        while (done !== 1'b1 && (cycNo - tStart) < 60) begin
            if (busy !== 1'b1) held = 1'b0;
            cyc();
        end
        check({tag, " latency"}, cycNo - tStart, 34);
        check({tag, " busy held"}, held, 1);
        check({tag, " busy@done"}, busy, 0);
        check({tag, " hi"}, hi, eHi);
        check({tag, " lo"}, lo, eLo);
        check({tag, " div0"}, div0, eDiv0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        cancel = 1'b0; hiWe = 1'b0; loWe = 1'b0; wdata = '0;
        rst8 = 1'b1; start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        cyc();
        cyc();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div0", div0, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst = 1'b0; rst8 = 1'b0; start = 1'b0;
        cyc();
        check("idle busy", busy, 0);

        launch(2'b01, 32'hFFFF_FFFD, 32'd7, "mult");
        waitDone("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        cyc();
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
        waitDone("multu", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        cyc();
        launch(2'b10, 32'd100, 32'd7, "divu");
        waitDone("divu", 32'd2, 32'd14, 1'b0);
        cyc();
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, "div neg");
        waitDone("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        cyc();
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        waitDone("div ovf", 32'd0, 32'h8000_0000, 1'b0);
        cyc();
        launch(2'b10, 32'd5, 32'd0, "divu0");
        waitDone("divu0", 32'd5, 32'hFFFF_FFFF, 1'b1);
        cyc();
        check("div0 one cycle", div0, 0);
        launch(2'b11, 32'hFFFF_FFF0, 32'd0, "div0 s");
        waitDone("div0 s", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        cyc();

        launch(2'b11, 32'd50, 32'd3, "cancel");
        for (int i = 0; i < 9; i++) cyc();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        #1;
        check("cancel busy", busy, 0);
        check("cancel hi", hi, 32'hFFFF_FFF0);
        check("cancel lo", lo, 32'hFFFF_FFFF);
        launch(2'b10, 32'd9, 32'd2, "after cancel");
        waitDone("after cancel", 32'd1, 32'd4, 1'b0);
        cyc();

        launch(2'b00, 32'd3, 32'd5, "we busy");
        for (int i = 0; i < 4; i++) cyc();
        hiWe = 1'b1; loWe = 1'b1; wdata = 32'hDEAD_BEEF;
        cyc();
        hiWe = 1'b0; loWe = 1'b0;
        check("we busy hi", hi, 32'd1);
        check("we busy lo", lo, 32'd4);
        waitDone("we busy", 32'd0, 32'd15, 1'b0);
        cyc();

        launch(2'b00, 32'd2, 32'd3, "b2b first");
        waitDone("b2b first", 32'd0, 32'd6, 1'b0);
        hiWe = 1'b1; wdata = 32'h0000_1234;
        launch(2'b10, 32'd20, 32'd6, "b2b second");
        hiWe = 1'b0;
        check("we at start hi", hi, 32'h0000_1234);
        check("we at start lo", lo, 32'd6);
        waitDone("b2b second", 32'd2, 32'd3, 1'b0);
        loWe = 1'b1; wdata = 32'h0000_5678;
        cyc();
        loWe = 1'b0;
        check("done we lo", lo, 32'h0000_5678);
        check("done we hi", hi, 32'd2);
        check("after done", done, 0);
        hiWe = 1'b1; wdata = 32'h0000_1234;
        cyc();
        hiWe = 1'b0;
        check("idle we hi", hi, 32'h0000_1234);

        start8 = 1'b1; op8 = 2'b01; a8 = 8'h80; b8 = 8'h80;
        tStart = cycNo;
        cyc();
        start8 = 1'b0;
        while (done8 !== 1'b1 && (cycNo - tStart) < 40) cyc();
        check("w8 latency", cycNo - tStart, 10);
        check("w8 hi", hi8, 8'h40);
        check("w8 lo", lo8, 8'h00);
        cyc();
        start8 = 1'b1; op8 = 2'b11; a8 = 8'd7; b8 = 8'd2;
        cyc();
        start8 = 1'b0;
        cyc();
        cyc();
        rst8 = 1'b1;
        cyc();
        check("w8 rst hi", hi8, 0);
        check("w8 rst lo", lo8, 0);
        check("w8 rst busy", busy8, 0);
        check("w8 rst done", done8, 0);
        check("w8 rst div0", div08, 0);
        rst8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (done8 === 1'b1) pulses++;
        end
        check("w8 no done", pulses, 0);
        check("w8 idle busy", busy8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nChecks, nFail);
        $finish;
    end

endmodule
